// File: rtl/mem_port_arbiter_if.sv
// Shared memory-port bus between the fetch/data arbiter (master) and the memory (slave).
interface mem_port_arbiter_if;
  logic        m_req;
  logic        m_write;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [1:0]  m_size;
  logic [31:0] m_rdata;
  logic        m_ready;

  modport master (
    output m_req, m_write, m_addr, m_wdata, m_size,
    input  m_rdata, m_ready
  );

  modport slave (
    input  m_req, m_write, m_addr, m_wdata, m_size,
    output m_rdata, m_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one memory port,
// with bounded data-over-fetch priority and a BUSY-cycle timeout that aborts hung transfers.
module mem_port_arbiter #(
  parameter int TIMEOUT    = 255,
  parameter int FAIR_LIMIT = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic [31:0]        if_rdata,
  output logic               if_ack,
  input  logic               d_req,
  input  logic               d_write,
  input  logic [31:0]        d_addr,
  input  logic [31:0]        d_wdata,
  input  logic [1:0]         d_size,
  output logic [31:0]        d_rdata,
  output logic               d_ack,
  output logic               stall_if,
  output logic               stall_mem,
  output logic               bus_err,
  mem_port_arbiter_if.master mem
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  localparam logic [15:0] FAIR_MAX = 16'(FAIR_LIMIT);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [15:0] fair_cnt;
  logic [15:0] busy_cnt;
  logic        if_ok;
  logic        d_ok;
  logic        fair_hit;
  logic        grant_i;
  logic        grant_d;
  logic        timeout_hit;

  // A port is not eligible in the cycle its own ack is high, so a held request is not replayed.
  assign if_ok    = if_req & ~if_ack;
  assign d_ok     = d_req & ~d_ack;
  assign fair_hit = (fair_cnt == FAIR_MAX);

  // A data request still held through its ack cycle counts as pending: the fetch waits
  // for it unless the data side has used up its consecutive-grant allowance.
  assign grant_i = (state == IDLE) & if_ok & (~d_req | fair_hit);
  assign grant_d = (state == IDLE) & d_ok & ~grant_i;

  assign timeout_hit = (busy_cnt == TO_LAST);

  assign mem.m_req = (state != IDLE);
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      mem.m_write <= 1'b0;
      mem.m_addr  <= '0;
      mem.m_wdata <= '0;
      mem.m_size  <= 2'b00;
      if_rdata    <= '0;
      d_rdata     <= '0;
      if_ack      <= 1'b0;
      d_ack       <= 1'b0;
      bus_err     <= 1'b0;
      fair_cnt    <= '0;
      busy_cnt    <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            state       <= BUSY_D;
            mem.m_write <= d_write;
            mem.m_addr  <= d_addr;
            mem.m_wdata <= d_wdata;
            mem.m_size  <= d_size;
            busy_cnt    <= '0;
            if (if_req && !fair_hit) fair_cnt <= fair_cnt + 16'd1;
          end else if (grant_i) begin
            state       <= BUSY_I;
            mem.m_write <= 1'b0;
            mem.m_addr  <= if_addr;
            mem.m_wdata <= '0;
            mem.m_size  <= 2'b10;
            busy_cnt    <= '0;
            fair_cnt    <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          // A timeout abort completes like a normal transfer but returns zero data.
          if (mem.m_ready || timeout_hit) begin
            state <= IDLE;
            if (state == BUSY_I) begin
              if_ack   <= 1'b1;
              if_rdata <= mem.m_ready ? mem.m_rdata : 32'd0;
            end else begin
              d_ack <= 1'b1;
              if (!mem.m_write) d_rdata <= mem.m_ready ? mem.m_rdata : 32'd0;
            end
            if (!mem.m_ready) bus_err <= 1'b1;
          end else begin
            busy_cnt <= busy_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester feeders, a latency-programmable memory
// responder, and a monitor that pops expected completions on every ack.
module tb_mem_port_arbiter;

  typedef struct {
    bit          is_d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [31:0] rdata;
    int          cycles;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_write = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [1:0]  d_size = 2'b00;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.TIMEOUT(4), .FAIR_LIMIT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_write   (d_write),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_size    (d_size),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .stall_if  (stall_if),
    .stall_mem (stall_mem),
    .bus_err   (bus_err),
    .mem       (bus.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  txn_t exp_q[$];
  txn_t if_q[$];
  txn_t d_q[$];
  logic [31:0] last_d = '0;

  int  wait_states = 0;
  bit  hang = 1'b0;
  bit  force_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a == 32'h0001_0000) return 32'h0000_0013;
    return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1234};
  endfunction

  task automatic add_fetch(input logic [31:0] a, input int cyc, input bit abort);
    txn_t t;
    t.is_d = 1'b0; t.wr = 1'b0; t.addr = a; t.wdata = '0; t.size = 2'b10;
    t.rdata = abort ? 32'd0 : mem_rd(a);
    t.cycles = cyc;
    if_q.push_back(t);
    exp_q.push_back(t);
  endtask

  task automatic add_data(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [1:0] sz, input int cyc);
    txn_t t;
    t.is_d = 1'b1; t.wr = wr; t.addr = a; t.wdata = wd; t.size = sz;
    t.rdata = wr ? last_d : mem_rd(a);
    t.cycles = cyc;
    if (!wr) last_d = t.rdata;
    d_q.push_back(t);
    exp_q.push_back(t);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || if_q.size() != 0 || d_q.size() != 0 || if_req || d_req)
           && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 0);
    if (n >= budget) begin
      exp_q.delete(); if_q.delete(); d_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Fetch requester: holds the request through its ack cycle, then moves on.
  bit   if_done = 1'b0;
  txn_t if_cur;
  always begin
    @(posedge clk); #1;
    if (if_req && if_ack) if_done = 1'b1;
    else if (if_done) begin
      if_done = 1'b0;
      if (if_q.size() > 0) begin if_cur = if_q.pop_front(); if_addr = if_cur.addr; end
      else if_req = 1'b0;
    end else if (!if_req && if_q.size() > 0) begin
      if_cur = if_q.pop_front(); if_addr = if_cur.addr; if_req = 1'b1;
    end
  end

  // Data requester.
  bit   d_done = 1'b0;
  txn_t d_cur;
  always begin
    @(posedge clk); #1;
    if (d_req && d_ack) d_done = 1'b1;
    else if (d_done) begin
      d_done = 1'b0;
      if (d_q.size() > 0) begin
        d_cur = d_q.pop_front();
        d_write = d_cur.wr; d_addr = d_cur.addr; d_wdata = d_cur.wdata; d_size = d_cur.size;
      end else d_req = 1'b0;
    end else if (!d_req && d_q.size() > 0) begin
      d_cur = d_q.pop_front();
      d_write = d_cur.wr; d_addr = d_cur.addr; d_wdata = d_cur.wdata; d_size = d_cur.size;
      d_req = 1'b1;
    end
  end

  // Memory: m_ready rises wait_states cycles after m_req; junk data while not ready.
  int wcnt = 0;
  always begin
    @(posedge clk); #1;
    if (force_ready) begin
      bus.m_ready = 1'b1; bus.m_rdata = 32'hFFFF_FFFF;
    end else if (bus.m_req && !hang) begin
      if (wcnt >= wait_states) begin bus.m_ready = 1'b1; bus.m_rdata = mem_rd(bus.m_addr); end
      else begin bus.m_ready = 1'b0; bus.m_rdata = 32'hBAD0_0000 ^ wcnt; end
      wcnt++;
    end else begin
      bus.m_ready = 1'b0; bus.m_rdata = 32'hBAD0_BAD0;
      if (!bus.m_req) wcnt = 0;
    end
  end

  // Monitor.
  int          busy_n = 0;
  logic [31:0] sv_addr, sv_wdata;
  logic        sv_wr;
  logic [1:0]  sv_size;
  txn_t        mt;
  always @(negedge clk) begin
    if (if_ack || d_ack) begin
      chk("dual_ack", {31'd0, if_ack & d_ack}, 32'd0);
      if (exp_q.size() == 0) chk("spurious_ack", exp_q.size(), 1);
      else begin
        mt = exp_q.pop_front();
        chk("ack_port", {31'd0, d_ack}, {31'd0, mt.is_d});
        chk("rdata", mt.is_d ? d_rdata : if_rdata, mt.rdata);
        chk("m_addr", sv_addr, mt.addr);
        chk("m_write", {31'd0, sv_wr}, {31'd0, mt.wr});
        chk("m_wdata", sv_wdata, mt.wdata);
        chk("m_size", {30'd0, sv_size}, {30'd0, mt.size});
        chk("busy_cycles", busy_n, mt.cycles);
        if (d_ack && d_req) chk("stall_mem_ack", {31'd0, stall_mem}, 32'd0);
        if (if_ack && if_req) chk("stall_if_ack", {31'd0, stall_if}, 32'd0);
      end
    end
    if (!bus.m_req) busy_n = 0;
    else begin
      if (busy_n > 0) begin
        chk("stable_addr", bus.m_addr, sv_addr);
        chk("stable_wdata", bus.m_wdata, sv_wdata);
        chk("stable_ctl", {29'd0, bus.m_write, bus.m_size}, {29'd0, sv_wr, sv_size});
      end
      if (d_req) chk("stall_mem_busy", {31'd0, stall_mem}, 32'd1);
      if (if_req) chk("stall_if_busy", {31'd0, stall_if}, 32'd1);
      sv_addr = bus.m_addr; sv_wdata = bus.m_wdata; sv_wr = bus.m_write; sv_size = bus.m_size;
      busy_n++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_req", {31'd0, bus.m_req}, 32'd0);
    chk("rst_m_write", {31'd0, bus.m_write}, 32'd0);
    chk("rst_m_addr", bus.m_addr, 32'd0);
    chk("rst_m_wdata", bus.m_wdata, 32'd0);
    chk("rst_m_size", {30'd0, bus.m_size}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_acks", {30'd0, if_ack, d_ack}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Single fetch at minimum latency.
    add_fetch(32'h0001_0000, 1, 1'b0);
    drain("drain_fetch", 40);

    // Fetch and store collide: data goes first.
    add_data(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 2'b00, 1);
    add_fetch(32'h0001_0004, 1, 1'b0);
    drain("drain_collide", 40);

    // Fairness: D, D, I, D, D, I.
    add_data(1'b0, 32'h0000_3000, 32'd0, 2'b10, 1);
    add_data(1'b0, 32'h0000_3004, 32'd0, 2'b10, 1);
    add_fetch(32'h0000_0400, 1, 1'b0);
    add_data(1'b0, 32'h0000_3008, 32'd0, 2'b01, 1);
    add_data(1'b0, 32'h0000_300C, 32'd0, 2'b10, 1);
    add_fetch(32'h0000_0404, 1, 1'b0);
    drain("drain_fair", 80);

    // m_ready while idle must not produce a completion.
    force_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("idle_ready_req", {31'd0, bus.m_req}, 32'd0);
      chk("idle_ready_ack", {30'd0, if_ack, d_ack}, 32'd0);
    end
    force_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Three wait states: ready lands on the last cycle before timeout.
    wait_states = 3;
    add_data(1'b0, 32'h0000_5000, 32'd0, 2'b10, 4);
    add_data(1'b1, 32'h0000_5004, 32'h1234_5678, 2'b01, 4);
    add_fetch(32'h0000_0500, 4, 1'b0);
    drain("drain_wait", 80);
    chk("no_err_at_limit", {31'd0, bus_err}, 32'd0);

    // Reset while a slow load is in flight.
    add_data(1'b0, 32'h0000_6000, 32'd0, 2'b10, 4);
    n = 0;
    while (!bus.m_req && n < 20) begin @(negedge clk); n++; end
    chk("rst_busy_seen", {31'd0, bus.m_req}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_m_req", {31'd0, bus.m_req}, 32'd0);
    chk("midrst_d_ack", {31'd0, d_ack}, 32'd0);
    chk("midrst_d_rdata", d_rdata, 32'd0);
    chk("midrst_d_req_held", {31'd0, d_req}, 32'd1);
    rst = 1'b1;
    drain("drain_rst", 40);

    // Timeout abort, then a good transfer: bus_err stays set.
    wait_states = 0;
    hang = 1'b1;
    add_fetch(32'h0000_7000, 4, 1'b1);
    drain("drain_timeout", 40);
    chk("bus_err_set", {31'd0, bus_err}, 32'd1);
    hang = 1'b0;
    add_data(1'b0, 32'h0000_7100, 32'd0, 2'b10, 1);
    add_fetch(32'h0000_7200, 1, 1'b0);
    drain("drain_after_to", 40);
    chk("bus_err_sticky", {31'd0, bus_err}, 32'd1);

    // Only reset clears bus_err.
    rst = 1'b0;
    @(negedge clk);
    chk("final_rst_err", {31'd0, bus_err}, 32'd0);
    chk("final_rst_rdata", if_rdata | d_rdata, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
